bubble_sort_ctrl: RTL and testbench



---
 rtl/bubble_sort_pkg.sv | 65 ++++++
 rtl/bubble_sort_ctrl_decode.sv | 93 +++++++++
 rtl/bubble_sort_ctrl.sv | 125 ++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_sort_pkg.sv
// Shared types and control encodings for the bubble-sort sequencer.
// Optional feature macro used by the controller: BSORT_EARLY_EXIT_EN.
package bubble_sort_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_OUTER_CMP,
        S_INNER_INIT,
        S_INNER_CMP,
        S_RD_A,
        S_RD_B,
        S_CMP_AB,
        S_WR_A,
        S_WR_B,
        S_INC_I,
        S_INC_J,
        S_DONE
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b11;
    localparam logic [1:0] M1_I    = 2'b00;
    localparam logic [1:0] M1_J    = 2'b01;
    localparam logic [1:0] M1_A    = 2'b10;
    localparam logic [1:0] M2_N1   = 2'b00;
    localparam logic [1:0] M2_B    = 2'b01;
    localparam logic [1:0] M2_ONE  = 2'b10;
    localparam logic [1:0] M4_I    = 2'b00;
    localparam logic [1:0] M4_K    = 2'b10;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       mem_en;
        logic       rw_mem;
        logic       clear_eoc;
        logic       preset_eoc;
        logic       ld_a;
        logic       ld_b;
        logic       ld_i;
        logic       ld_j;
        logic       ld_k;
        logic       ld_n_1;
        logic       sel_m3;
        logic       sel_m5;
        logic       sel_m6;
        logic       sel_m7;
        logic       sel_m8;
        logic [1:0] sel_m1;
        logic [1:0] sel_m2;
        logic [1:0] sel_m4;
        logic [1:0] alu_sel;
    } ctrl_t;

    // Host owns the memory port in IDLE: address from addr_ptr, data from data_in.
    localparam ctrl_t CTRL_IDLE = '{
        busy: 1'b0, done: 1'b0, mem_en: 1'b0, rw_mem: 1'b0,
        clear_eoc: 1'b0, preset_eoc: 1'b0,
        ld_a: 1'b0, ld_b: 1'b0, ld_i: 1'b0, ld_j: 1'b0, ld_k: 1'b0, ld_n_1: 1'b0,
        sel_m3: 1'b0, sel_m5: 1'b0, sel_m6: 1'b0, sel_m7: 1'b1, sel_m8: 1'b1,
        sel_m1: M1_I, sel_m2: M2_N1, sel_m4: M4_I, alu_sel: ALU_ADD
    };

endpackage

// File: rtl/bubble_sort_ctrl_decode.sv
// Combinational state-to-control-word decoder for the bubble-sort datapath.
// Only IDLE looks at anything besides the state (host memory pass-through).
module bubble_sort_ctrl_decode
    import bubble_sort_pkg::*;
(
    input  state_t i_state,
    input  logic   i_host_we,
    input  logic   i_host_re,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl      = '0;
        o_ctrl.busy = 1'b1;
        unique case (i_state)
            S_IDLE: begin
                o_ctrl        = CTRL_IDLE;
                o_ctrl.mem_en = i_host_we | i_host_re;
                o_ctrl.rw_mem = i_host_we;
            end
            S_INIT: begin
                o_ctrl.clear_eoc = 1'b1;
                o_ctrl.ld_j      = 1'b1;
                o_ctrl.sel_m6    = 1'b1;
                o_ctrl.ld_n_1    = 1'b1;
            end
            S_OUTER_CMP: begin
                o_ctrl.alu_sel = ALU_CMP;
                o_ctrl.sel_m1  = M1_J;
                o_ctrl.sel_m2  = M2_N1;
            end
            S_INNER_INIT: begin
                o_ctrl.ld_i   = 1'b1;
                o_ctrl.sel_m5 = 1'b1;
            end
            S_INNER_CMP: begin
                o_ctrl.alu_sel = ALU_CMP;
                o_ctrl.sel_m1  = M1_I;
                o_ctrl.sel_m2  = M2_N1;
            end
            S_RD_A: begin
                // Read a[i] while the ALU forms k = i + 1 in the same cycle.
                o_ctrl.mem_en  = 1'b1;
                o_ctrl.sel_m4  = M4_I;
                o_ctrl.ld_a    = 1'b1;
                o_ctrl.alu_sel = ALU_ADD;
                o_ctrl.sel_m1  = M1_I;
                o_ctrl.sel_m2  = M2_ONE;
                o_ctrl.ld_k    = 1'b1;
            end
            S_RD_B: begin
                o_ctrl.mem_en = 1'b1;
                o_ctrl.sel_m4 = M4_K;
                o_ctrl.ld_b   = 1'b1;
            end
            S_CMP_AB: begin
                o_ctrl.alu_sel = ALU_CMP;
                o_ctrl.sel_m1  = M1_A;
                o_ctrl.sel_m2  = M2_B;
            end
            S_WR_A: begin
                o_ctrl.mem_en = 1'b1;
                o_ctrl.rw_mem = 1'b1;
                o_ctrl.sel_m3 = 1'b1;
                o_ctrl.sel_m4 = M4_I;
            end
            S_WR_B: begin
                o_ctrl.mem_en = 1'b1;
                o_ctrl.rw_mem = 1'b1;
                o_ctrl.sel_m3 = 1'b0;
                o_ctrl.sel_m4 = M4_K;
            end
            S_INC_I: begin
                o_ctrl.alu_sel = ALU_ADD;
                o_ctrl.sel_m1  = M1_I;
                o_ctrl.sel_m2  = M2_ONE;
                o_ctrl.ld_i    = 1'b1;
            end
            S_INC_J: begin
                o_ctrl.alu_sel = ALU_ADD;
                o_ctrl.sel_m1  = M1_J;
                o_ctrl.sel_m2  = M2_ONE;
                o_ctrl.ld_j    = 1'b1;
            end
            S_DONE: begin
                o_ctrl.preset_eoc = 1'b1;
                o_ctrl.done       = 1'b1;
            end
            default: o_ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Sequencing FSM for the in-place bubble-sort datapath plus host/engine memory arbitration.
// Define BSORT_EARLY_EXIT_EN to finish as soon as a full pass makes no swap.
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter int N = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       host_we,
    input  logic       host_re,
    input  logic       in_1_eq_in_2,
    input  logic       in_1_gt_in_2,
    input  logic       in_1_lt_in_2,
    output logic       busy,
    output logic       done,
    output logic       mem_en,
    output logic       RW_MEM,
    output logic       clear_eoc,
    output logic       preset_eoc,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_i,
    output logic       ld_j,
    output logic       ld_k,
    output logic       ld_n_1,
    output logic       sel_m3,
    output logic       sel_m5,
    output logic       sel_m6,
    output logic       sel_m7,
    output logic       sel_m8,
    output logic [1:0] sel_m1,
    output logic [1:0] sel_m2,
    output logic [1:0] sel_m4,
    output logic [1:0] ALU_sel
);

    if (N < 1) begin : g_bad_n
        $fatal(1, "bubble_sort_ctrl: N must be at least 1");
    end

    state_t r_state;
    ctrl_t  w_ctrl;
    logic   w_lt;
    logic   w_gt;
`ifdef BSORT_EARLY_EXIT_EN
    logic   r_swapped;
`endif

    // Flags are mutually exclusive from a sane ALU; eq vetoes a conflicting lt/gt.
    assign w_lt = in_1_lt_in_2 & ~in_1_eq_in_2;
    assign w_gt = in_1_gt_in_2 & ~in_1_eq_in_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
`ifdef BSORT_EARLY_EXIT_EN
            r_swapped <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE:       if (start) r_state <= S_INIT;
                S_INIT:       r_state <= S_OUTER_CMP;
                S_OUTER_CMP:  r_state <= w_lt ? S_INNER_INIT : S_DONE;
                S_INNER_INIT: r_state <= S_INNER_CMP;
                S_INNER_CMP: begin
                    if (w_lt)
                        r_state <= S_RD_A;
                    else
`ifdef BSORT_EARLY_EXIT_EN
                        r_state <= r_swapped ? S_INC_J : S_DONE;
`else
                        r_state <= S_INC_J;
`endif
                end
                S_RD_A:       r_state <= S_RD_B;
                S_RD_B:       r_state <= S_CMP_AB;
                S_CMP_AB:     r_state <= w_gt ? S_WR_A : S_INC_I;
                S_WR_A:       r_state <= S_WR_B;
                S_WR_B:       r_state <= S_INC_I;
                S_INC_I:      r_state <= S_INNER_CMP;
                S_INC_J:      r_state <= S_OUTER_CMP;
                S_DONE:       r_state <= S_IDLE;
                default:      r_state <= S_IDLE;
            endcase
`ifdef BSORT_EARLY_EXIT_EN
            if (r_state == S_INNER_INIT)
                r_swapped <= 1'b0;
            else if (r_state == S_WR_A)
                r_swapped <= 1'b1;
`endif
        end
    end

    bubble_sort_ctrl_decode u_decode (
        .i_state   (r_state),
        .i_host_we (host_we),
        .i_host_re (host_re),
        .o_ctrl    (w_ctrl)
    );

    assign busy       = w_ctrl.busy;
    assign done       = w_ctrl.done;
    assign mem_en     = w_ctrl.mem_en;
    assign RW_MEM     = w_ctrl.rw_mem;
    assign clear_eoc  = w_ctrl.clear_eoc;
    assign preset_eoc = w_ctrl.preset_eoc;
    assign ld_a       = w_ctrl.ld_a;
    assign ld_b       = w_ctrl.ld_b;
    assign ld_i       = w_ctrl.ld_i;
    assign ld_j       = w_ctrl.ld_j;
    assign ld_k       = w_ctrl.ld_k;
    assign ld_n_1     = w_ctrl.ld_n_1;
    assign sel_m3     = w_ctrl.sel_m3;
    assign sel_m5     = w_ctrl.sel_m5;
    assign sel_m6     = w_ctrl.sel_m6;
    assign sel_m7     = w_ctrl.sel_m7;
    assign sel_m8     = w_ctrl.sel_m8;
    assign sel_m1     = w_ctrl.sel_m1;
    assign sel_m2     = w_ctrl.sel_m2;
    assign sel_m4     = w_ctrl.sel_m4;
    assign ALU_sel    = w_ctrl.alu_sel;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: a behavioural datapath/memory closes the loop, and each
// sort is checked against a plain array bubble sort with cycle costs counted per step.
module tb_bubble_sort_ctrl;

    localparam int N = 16;
`ifdef BSORT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, host_we, host_re;
    logic in_1_eq_in_2, in_1_gt_in_2, in_1_lt_in_2;
    logic busy, done, mem_en, RW_MEM, clear_eoc, preset_eoc;
    logic ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1;
    logic sel_m3, sel_m5, sel_m6, sel_m7, sel_m8;
    logic [1:0] sel_m1, sel_m2, sel_m4, ALU_sel;

    always #5 clk = ~clk;

    bubble_sort_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .host_we(host_we), .host_re(host_re),
        .in_1_eq_in_2(in_1_eq_in_2), .in_1_gt_in_2(in_1_gt_in_2), .in_1_lt_in_2(in_1_lt_in_2),
        .busy(busy), .done(done), .mem_en(mem_en), .RW_MEM(RW_MEM),
        .clear_eoc(clear_eoc), .preset_eoc(preset_eoc),
        .ld_a(ld_a), .ld_b(ld_b), .ld_i(ld_i), .ld_j(ld_j), .ld_k(ld_k), .ld_n_1(ld_n_1),
        .sel_m3(sel_m3), .sel_m5(sel_m5), .sel_m6(sel_m6), .sel_m7(sel_m7), .sel_m8(sel_m8),
        .sel_m1(sel_m1), .sel_m2(sel_m2), .sel_m4(sel_m4), .ALU_sel(ALU_sel)
    );

    // ---------------- behavioural datapath ----------------
    logic [N-1:0] mem [16];
    logic [N-1:0] ra, rb, ri, rj, rk, rn1;
    logic         eoc;
    logic [N-1:0] addr_ptr, data_in;
    logic [N-1:0] m1, m2, alu, addr, wdata, rdata;

    always_comb begin
        m1    = (sel_m1 == 2'b00) ? ri : (sel_m1 == 2'b01) ? rj : ra;
        m2    = (sel_m2 == 2'b00) ? rn1 : (sel_m2 == 2'b01) ? rb : N'(1);
        alu   = m1 + m2;
        addr  = sel_m8 ? addr_ptr : ((sel_m4 == 2'b10) ? rk : ri);
        wdata = sel_m7 ? data_in : (sel_m3 ? rb : ra);
        rdata = mem[addr[3:0]];
    end

    assign in_1_eq_in_2 = (ALU_sel == 2'b11) && (m1 == m2);
    assign in_1_gt_in_2 = (ALU_sel == 2'b11) && (m1 >  m2);
    assign in_1_lt_in_2 = (ALU_sel == 2'b11) && (m1 <  m2);

    always @(posedge clk) begin
        if (mem_en && RW_MEM) mem[addr[3:0]] <= wdata;
        if (mem_en && !RW_MEM && ld_a) ra <= rdata;
        if (mem_en && !RW_MEM && ld_b) rb <= rdata;
        if (ld_i)   ri  <= sel_m5 ? '0 : alu;
        if (ld_j)   rj  <= sel_m6 ? '0 : alu;
        if (ld_k)   rk  <= alu;
        if (ld_n_1) rn1 <= data_in;
        if (clear_eoc)  eoc <= 1'b0;
        if (preset_eoc) eoc <= 1'b1;
    end

    int nwr_a = 0;
    int ndone = 0;
    always @(posedge clk) begin
        if (!rst && mem_en && RW_MEM && !sel_m8 && sel_m3) nwr_a <= nwr_a + 1;
        if (done) ndone <= ndone + 1;
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    int exp_arr [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain bubble sort on exp_arr, totting up cycles per step.
    task automatic ref_run(input int n1, output int sw, output int cyc);
        int s, t;
        sw  = 0;
        cyc = 1;                                   // INIT
        for (int p = 0; p < n1; p++) begin
            cyc += 2;                              // OUTER_CMP, INNER_INIT
            s = 0;
            for (int x = 0; x < n1; x++) begin
                cyc += 5;
                if (exp_arr[x] > exp_arr[x+1]) begin
                    t = exp_arr[x]; exp_arr[x] = exp_arr[x+1]; exp_arr[x+1] = t;
                    s++;
                    cyc += 2;
                end
            end
            sw  += s;
            cyc += 1;                              // final INNER_CMP
            if (EARLY && s == 0) begin
                cyc += 1;                          // DONE
                return;
            end
            cyc += 1;                              // INC_J
        end
        cyc += 2;                                  // final OUTER_CMP, DONE
    endtask

    task automatic host_write(input int a, input int v);
        @(negedge clk);
        host_we = 1'b1; addr_ptr = N'(a); data_in = N'(v);
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic load_arr(input int n1);
        for (int x = 0; x <= n1; x++) host_write(x, exp_arr[x]);
    endtask

    task automatic run_sort(input string tag, input int n1, input bit noisy);
        int sw, ecyc, w0, d0, cnt, mism;
        logic [N-1:0] keep15;
        ref_run(n1, sw, ecyc);
        w0 = nwr_a; d0 = ndone; keep15 = mem[15];
        @(negedge clk);
        start = 1'b1; data_in = N'(n1);
        @(negedge clk);
        start = 1'b0; cnt = 1;
        check({tag, "_init"}, {busy, ld_n_1, ld_j, sel_m6, clear_eoc, done}, 6'b111110);
        while (!done && cnt < 4000) begin
            @(negedge clk);
            cnt++;
            if (noisy) begin
                start = cnt[0]; host_we = 1'b1; host_re = cnt[1];
                addr_ptr = N'(15); data_in = 16'hBEEF;
            end
        end
        start = 1'b0; host_we = 1'b0; host_re = 1'b0;
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_cycles"}, cnt, ecyc);
        @(negedge clk);
        check({tag, "_idle_after"}, {busy, done, eoc}, 3'b001);
        check({tag, "_swaps"}, nwr_a - w0, sw);
        check({tag, "_one_done"}, ndone - d0, 1);
        mism = 0;
        for (int x = 0; x <= n1; x++) if (mem[x] !== N'(exp_arr[x])) mism++;
        check({tag, "_sorted"}, mism, 0);
        if (noisy) check({tag, "_host_ignored"}, mem[15], keep15);
    endtask

    initial begin
        int n1, cnt, d0;
        bit found;
        rst = 1'b1; start = 1'b0; host_we = 1'b0; host_re = 1'b0;
        addr_ptr = '0; data_in = '0;

        repeat (3) begin
            @(negedge clk);
            check("reset_out", {busy, done, mem_en, sel_m7, sel_m8, ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1},
                  11'b00011000000);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_out", {busy, done, mem_en, RW_MEM, sel_m7, sel_m8}, 6'b000011);

        // Host arbitration in IDLE: write wins over read.
        host_we = 1'b1; host_re = 1'b1; addr_ptr = N'(15); data_in = 16'h00A5;
        #1 check("host_we_re", {mem_en, RW_MEM, sel_m8, sel_m7}, 4'b1111);
        @(negedge clk);
        host_we = 1'b0; addr_ptr = '0;
        #1 check("host_re", {mem_en, RW_MEM, ld_a}, 3'b100);
        host_re = 1'b0;
        check("host_wr_mem", mem[15], 16'h00A5);

        // n = 1: nothing to sort.
        exp_arr[0] = 42; load_arr(0);
        run_sort("n1_zero", 0, 1'b0);

        exp_arr[0] = 2; exp_arr[1] = 5; load_arr(1);
        run_sort("two_sorted", 1, 1'b0);

        exp_arr[0] = 9; exp_arr[1] = 7; exp_arr[2] = 5; exp_arr[3] = 3; load_arr(3);
        run_sort("descending", 3, 1'b0);

        exp_arr[0] = 1; exp_arr[1] = 2; exp_arr[2] = 3; exp_arr[3] = 4; load_arr(3);
        run_sort("ascending", 3, 1'b0);

        for (int r = 0; r < 5; r++) begin
            n1 = $urandom_range(1, 6);
            for (int x = 0; x <= n1; x++) exp_arr[x] = $urandom_range(0, 999);
            load_arr(n1);
            run_sort("random", n1, r == 2);
        end

        // Abort during WR_B, then re-sort whatever the memory holds.
        exp_arr[0] = 9; exp_arr[1] = 7; exp_arr[2] = 5; exp_arr[3] = 3; load_arr(3);
        d0 = ndone;
        @(negedge clk);
        start = 1'b1; data_in = N'(3);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0; cnt = 0;
        while (!found && cnt < 500) begin
            if (mem_en && RW_MEM && !sel_m8 && !sel_m3) found = 1'b1;
            else begin @(negedge clk); cnt++; end
        end
        check("wr_b_seen", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle", {busy, done, sel_m7, sel_m8}, 4'b0011);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", ndone - d0, 0);
        check("abort_eoc", eoc, 1'b0);
        for (int x = 0; x <= 3; x++) exp_arr[x] = int'(mem[x]);
        run_sort("after_abort", 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
